mul_seq_ctrl: RTL and testbench
===============================

// Module: mul_seq_ctrl
// PURPOSE
// Sequencer wrapping the combinational unsigned mul32x32 array as the RV32M execute unit.
// Accepts MUL/MULH/MULHSU/MULHU over a valid/ready handshake and converts signed operands to magnitudes.
// Holds the array inputs stable for a programmable multicycle window, applies sign correction and returns the selected 32-bit half.
// Sits between decode/issue and writeback; flushable by the pipeline.
// PARAMETERS
// MUL_CYCLES  2  cycles the array inputs are held before capture (>=1; multicycle timing path)
// TAG_W       5  width of pass-through tag (destination register index)
// PORTS
// clk         in   1      clock, rising edge
// rst         in   1      asynchronous reset, active-high
// in_valid    in   1      request valid
// in_ready    out  1      unit can accept (high only in IDLE)
// in_op       in   2      00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
// in_rs1      in   32     multiplicand
// in_rs2      in   32     multiplier
// in_tag      in   TAG_W  tag returned with result
// flush       in   1      kill in-flight op
// out_valid   out  1      result valid
// out_ready   in   1      consumer accepts result
// out_result  out  32     selected product half
// out_tag     out  TAG_W  tag of this result
// busy        out  1      state != IDLE
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, out_valid=0, out_result=0, out_tag=0, busy=0, counter=0; in_ready=1 after deassert.
// - FSM: IDLE -> CONV -> MUL -> FIX -> DONE -> IDLE.
//   IDLE: in_ready=1; in_valid&&!flush at edge latches op, rs1, rs2 and tag -> CONV.
//   CONV: sign1 = rs1[31] & (op==MULH|op==MULHSU); sign2 = rs2[31] & (op==MULH).
//         Registers abs operands (two's-complement negate when sign set); neg = sign1^sign2.
//         Loads counter = MUL_CYCLES-1. -> MUL.
//   MUL:  abs operands drive the array; decrement each cycle.
//         At counter==0, capture the 64-bit product -> FIX.
//   FIX:  product = neg ? (~product+1) mod 2^64 : product.
//         out_result = (op==MUL) ? product[31:0] : product[63:32]; out_tag = tag. -> DONE.
//   DONE: out_valid=1; out_result and out_tag held stable while out_ready=0.
//         out_valid&&out_ready -> IDLE (in_ready rises the next cycle; no same-cycle re-accept).
// - Latency: accept edge to out_valid high = MUL_CYCLES+3 cycles (5 at default).
// - MUL ignores signedness (low half identical); treated as unsigned.
// - |-2^31| = 0x80000000 fits the unsigned operand; no overflow case exists.
// - flush: from any state, next edge -> IDLE, out_valid=0, result discarded.
//   flush && in_valid in IDLE: not accepted. flush && out_ready in DONE: no transfer counted.
// - Illegal/unused state encodings -> IDLE.
// STRUCTURE
// - Shared package mul_pkg: op encodings (OP_MUL..OP_MULHU), FSM state enum, XLEN=32.
// - One sub-module: the existing mul32x32 array instance (64-bit product).
// - Negation (operand and product) is inline logic in this block.
// TESTING
// - MUL 7 x 6, out_ready=1 -> out_valid exactly 5 cycles after accept, out_result=0x0000002A, tag echoed.
// - 0xFFFFFFFF x 0xFFFFFFFF: MULH -> 0x00000000; MULHU -> 0xFFFFFFFE; MUL -> 0x00000001.
// - MULHSU 0x80000000 x 0xFFFFFFFF -> 0x80000000; MULH 0x80000000 x 0x80000000 -> 0x40000000.
// - Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid=1, result/tag stable, in_ready=0; release -> IDLE next cycle.
// - flush on 2nd MUL cycle -> IDLE next edge, in_ready=1, out_valid never asserts; next op result correct.
// - rst asserted mid-FIX (asynchronously) -> outputs zero immediately; new MULHU 0x10000 x 0x10000 -> 0x00000001.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the RV32M multiply sequencer: operand width, op encodings, FSM states.
package mul_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned PROD_W = 2 * XLEN;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CONV = 3'd1,
        ST_MUL  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/mul32x32.sv
// Combinational unsigned 32x32 -> 64 multiplier array; inputs must be held for the multicycle window.
module mul32x32
    import mul_pkg::*;
(
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [PROD_W-1:0] p
);

    assign p = PROD_W'(a) * PROD_W'(b);

endmodule

// File: rtl/mul_seq_ctrl.sv
// RV32M multiply sequencer: converts signed operands to magnitudes, holds them on the array
// for MUL_CYCLES cycles, then sign-corrects the product and returns the requested half.
module mul_seq_ctrl
    import mul_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned TAG_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int unsigned CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    state_e              state, state_nxt;
    op_e                 op_q, op_d;
    logic [XLEN-1:0]     rs1_q, rs1_d;
    logic [XLEN-1:0]     rs2_q, rs2_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [XLEN-1:0]     a_abs_q, a_abs_d;
    logic [XLEN-1:0]     b_abs_q, b_abs_d;
    logic                neg_q, neg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PROD_W-1:0]   prod_q, prod_d;
    logic [PROD_W-1:0]   prod_arr;
    logic [PROD_W-1:0]   prod_fixed;
    logic                sign1, sign2;
    logic                out_valid_d, in_ready_d, busy_d;
    logic [XLEN-1:0]     out_result_d;
    logic [TAG_W-1:0]    out_tag_d;

    mul32x32 u_array (
        .a (a_abs_q),
        .b (b_abs_q),
        .p (prod_arr)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-register values
    always_comb begin
        state_nxt    = state;
        op_d         = op_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        tag_d        = tag_q;
        a_abs_d      = a_abs_q;
        b_abs_d      = b_abs_q;
        neg_d        = neg_q;
        cnt_d        = cnt_q;
        prod_d       = prod_q;
        out_result_d = out_result;
        out_tag_d    = out_tag;
        sign1        = 1'b0;
        sign2        = 1'b0;
        prod_fixed   = prod_q;

        case (state)
            ST_IDLE: begin
                if (in_valid && !flush) begin
                    op_d      = op_e'(in_op);
                    rs1_d     = in_rs1;
                    rs2_d     = in_rs2;
                    tag_d     = in_tag;
                    state_nxt = ST_CONV;
                end
            end
            ST_CONV: begin
                sign1     = rs1_q[XLEN-1] & ((op_q == OP_MULH) | (op_q == OP_MULHSU));
                sign2     = rs2_q[XLEN-1] & (op_q == OP_MULH);
                a_abs_d   = sign1 ? (~rs1_q + XLEN'(1)) : rs1_q;
                b_abs_d   = sign2 ? (~rs2_q + XLEN'(1)) : rs2_q;
                neg_d     = sign1 ^ sign2;
                cnt_d     = CNT_W'(MUL_CYCLES - 1);
                state_nxt = ST_MUL;
            end
            ST_MUL: begin
                if (cnt_q == '0) begin
                    prod_d    = prod_arr;
                    state_nxt = ST_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_FIX: begin
                prod_fixed   = neg_q ? (~prod_q + PROD_W'(1)) : prod_q;
                out_result_d = (op_q == OP_MUL) ? prod_fixed[XLEN-1:0] : prod_fixed[PROD_W-1:XLEN];
                out_tag_d    = tag_q;
                state_nxt    = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Flush wins over every transition, including a DONE handshake
        if (flush) begin
            state_nxt = ST_IDLE;
        end

        out_valid_d = (state_nxt == ST_DONE);
        in_ready_d  = (state_nxt == ST_IDLE);
        busy_d      = (state_nxt != ST_IDLE);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= OP_MUL;
            rs1_q      <= '0;
            rs2_q      <= '0;
            tag_q      <= '0;
            a_abs_q    <= '0;
            b_abs_q    <= '0;
            neg_q      <= 1'b0;
            cnt_q      <= '0;
            prod_q     <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
        end else begin
            op_q       <= op_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            tag_q      <= tag_d;
            a_abs_q    <= a_abs_d;
            b_abs_q    <= b_abs_d;
            neg_q      <= neg_d;
            cnt_q      <= cnt_d;
            prod_q     <= prod_d;
            out_valid  <= out_valid_d;
            out_result <= out_result_d;
            out_tag    <= out_tag_d;
            in_ready   <= in_ready_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed self-checking bench for mul_seq_ctrl: latency, signed/unsigned halves, backpressure, flush, async reset.
module tb_mul_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [4:0]  in_tag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        busy;

    int n_checks;
    int n_fail;

    mul_seq_ctrl #(.MUL_CYCLES(2), .TAG_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one request; returns one cycle after the accepting edge (CONV cycle)
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        n_checks++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL issue_ready: in_ready=%0b after %0d cycles, required 1", in_ready, w);
        end
        in_valid = 1'b1;
        in_op    = op;
        in_rs1   = a;
        in_rs2   = b;
        in_tag   = tag;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Cycle 1 is the CONV cycle right after the accept edge; counts until out_valid is seen
    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++;
        if (!out_valid) begin
            n_fail++;
            $display("FAIL wait_valid: out_valid=0 after %0d cycles, required 1", cyc);
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, output logic [31:0] res, output logic [4:0] rtag,
                          output int lat);
        out_ready = 1'b1;
        issue(op, a, b, tag);
        wait_valid(lat);
        res  = out_result;
        rtag = out_tag;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        n_checks += 4;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b, required 0", out_valid); end
        if (out_result !== 32'h0) begin n_fail++; $display("FAIL reset_out_result: got %h, required 00000000", out_result); end
        if (out_tag !== 5'd0) begin n_fail++; $display("FAIL reset_out_tag: got %0d, required 0", out_tag); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b, required 0", busy); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b, required 1", in_ready); end
    endtask

    task automatic test_basic_latency();
        logic [31:0] res;
        logic [4:0]  rtag;
        int          lat;
        run_op(2'b00, 32'd7, 32'd6, 5'd9, res, rtag, lat);
        n_checks += 3;
        if (lat !== 5) begin n_fail++; $display("FAIL mul_latency: got %0d cycles, required 5", lat); end
        if (res !== 32'h0000002A) begin n_fail++; $display("FAIL mul_7x6: got %h, required 0000002a", res); end
        if (rtag !== 5'd9) begin n_fail++; $display("FAIL mul_tag: got %0d, required 9", rtag); end
    endtask

    task automatic test_halves();
        logic [1:0]  ops [5] = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b01};
        logic [31:0] as  [5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000};
        logic [31:0] bs  [5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
        logic [31:0] exp [5] = '{32'h00000000, 32'hFFFFFFFE, 32'h00000001, 32'h80000000, 32'h40000000};
        logic [31:0] res;
        logic [4:0]  rtag;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            run_op(ops[i], as[i], bs[i], 5'(i + 1), res, rtag, lat);
            n_checks += 2;
            if (res !== exp[i]) begin
                n_fail++;
                $display("FAIL halves_%0d op=%0d: got %h, required %h", i, ops[i], res, exp[i]);
            end
            if (rtag !== 5'(i + 1)) begin
                n_fail++;
                $display("FAIL halves_tag_%0d: got %0d, required %0d", i, rtag, i + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        out_ready = 1'b0;
        issue(2'b11, 32'h00010000, 32'h00030000, 5'd17);
        wait_valid(lat);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1 || out_result !== 32'h00000003 || out_tag !== 5'd17 || in_ready !== 1'b0)
                bad++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_hold: %0d unstable cycles (valid=%0b res=%h tag=%0d rdy=%0b), required 0",
                     bad, out_valid, out_result, out_tag, in_ready);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks += 2;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %0b, required 0", out_valid); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %0b, required 1", in_ready); end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        logic [4:0]  rtag;
        int          lat;
        int          seen;
        out_ready = 1'b1;
        issue(2'b00, 32'd3, 32'd5, 5'd3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_checks += 2;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %0b, required 1", in_ready); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %0b, required 0", busy); end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b0) seen++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (seen != 0) begin n_fail++; $display("FAIL flush_no_valid: out_valid high %0d cycles, required 0", seen); end
        run_op(2'b01, 32'hFFFFFFFE, 32'd3, 5'd12, res, rtag, lat);
        n_checks += 2;
        if (res !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL flush_next_op: got %h, required ffffffff", res); end
        if (rtag !== 5'd12) begin n_fail++; $display("FAIL flush_next_tag: got %0d, required 12", rtag); end
    endtask

    task automatic test_async_reset();
        logic [31:0] res;
        logic [4:0]  rtag;
        int          lat;
        out_ready = 1'b0;
        issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd21);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL ares_busy_before: got %0b, required 1", busy); end
        #2 rst = 1'b1;
        #1;
        n_checks += 4;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ares_out_valid: got %0b, required 0", out_valid); end
        if (out_result !== 32'h0) begin n_fail++; $display("FAIL ares_out_result: got %h, required 00000000", out_result); end
        if (out_tag !== 5'd0) begin n_fail++; $display("FAIL ares_out_tag: got %0d, required 0", out_tag); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL ares_busy: got %0b, required 0", busy); end
        #2 rst = 1'b0;
        @(posedge clk); #1;
        run_op(2'b11, 32'h00010000, 32'h00010000, 5'd4, res, rtag, lat);
        n_checks += 2;
        if (res !== 32'h00000001) begin n_fail++; $display("FAIL ares_next_op: got %h, required 00000001", res); end
        if (rtag !== 5'd4) begin n_fail++; $display("FAIL ares_next_tag: got %0d, required 4", rtag); end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_rs1    = '0;
        in_rs2    = '0;
        in_tag    = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_basic_latency();
        test_halves();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
